// File: rtl/instr_loader_pkg.sv
// Shared instruction-format definitions for the program loader and the decoder.
// Field order, the I-type opcode set and the loader state encoding are all defined here.
package instr_loader_pkg;

    localparam int WORD_W  = 16;
    localparam int FIELD_W = 4;
    localparam int OP_LSB  = 12;
    localparam int RS1_LSB = 8;
    localparam int RS2_LSB = 4;
    localparam int RA_LSB  = 0;

    // I-type opcodes occupy one contiguous range; ra carries an immediate for these.
    localparam logic [3:0] OP_ITYPE_FIRST = 4'd5;
    localparam logic [3:0] OP_ITYPE_LAST  = 4'd8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Member order matches the word layout, MSB first: op, rs1, rs2, ra.
    typedef struct packed {
        logic [FIELD_W-1:0] op;
        logic [FIELD_W-1:0] rs1;
        logic [FIELD_W-1:0] rs2;
        logic [FIELD_W-1:0] ra;
    } instr_fields_t;

    function automatic logic is_itype(input logic [3:0] op);
        return (op >= OP_ITYPE_FIRST) && (op <= OP_ITYPE_LAST);
    endfunction

    function automatic logic [WORD_W-1:0] checksum_next(input logic [WORD_W-1:0] acc,
                                                        input logic [WORD_W-1:0] word);
        return acc ^ word;
    endfunction

endpackage

// File: rtl/instr_loader_pack.sv
// Combinational field packer: builds the instruction word and flags I-type and legal opcodes.
module instr_pack
    import instr_loader_pkg::*;
#(
    parameter int MAX_OP = 8
) (
    input  logic [3:0]  op,
    input  logic [3:0]  rs1,
    input  logic [3:0]  rs2,
    input  logic [3:0]  ra,
    output logic [15:0] word,
    output logic        reg_imm,
    output logic        legal
);

    localparam logic [4:0] MAX_OP_C = 5'(MAX_OP);

    instr_fields_t fields_s;

    // Pack fields into the decoder's layout and classify the opcode.
    always_comb begin
        fields_s.op  = op;
        fields_s.rs1 = rs1;
        fields_s.rs2 = rs2;
        fields_s.ra  = ra;
        word         = fields_s;
        reg_imm      = is_itype(op);
        legal        = ({1'b0, op} <= MAX_OP_C);
    end

endmodule

// File: rtl/instr_loader.sv
// Program-loading front end: packs field beats into instruction words and writes them
// sequentially into instruction RAM, tracking count, XOR checksum and illegal opcodes.
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256,
    parameter int MAX_OP = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [3:0]        in_rs1,
    input  logic [3:0]        in_rs2,
    input  logic [3:0]        in_ra,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              wr_imm,
    output logic [ADDR_W:0]   count,
    output logic [15:0]       checksum,
    output logic              full,
    output logic              done,
    output logic              err_illegal
);

    localparam logic [ADDR_W:0] ONE_C  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] LAST_C = (ADDR_W+1)'(DEPTH) - ONE_C;

    logic [1:0]        state_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [15:0]       mem_wdata_r;
    logic              wr_imm_r;
    logic [ADDR_W:0]   count_r;
    logic [15:0]       checksum_r;
    logic              full_r;
    logic              done_r;
    logic              err_r;

    logic [15:0]       word_s;
    logic              imm_s;
    logic              legal_s;
    logic              accept_s;
    logic              write_s;
    logic              last_s;

    instr_pack #(.MAX_OP(MAX_OP)) u_pack (
        .op      (in_op),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .ra      (in_ra),
        .word    (word_s),
        .reg_imm (imm_s),
        .legal   (legal_s)
    );

    // Handshake decode; in_ready depends only on state and full so it never loops through in_valid.
    always_comb begin
        in_ready = (state_r == ST_LOAD) && !full_r;
        accept_s = in_valid && in_ready;
        write_s  = accept_s && legal_s;
        last_s   = write_s && (count_r == LAST_C);
    end

    // Session FSM plus the registered write port and session statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 16'h0000;
            wr_imm_r    <= 1'b0;
            count_r     <= '0;
            checksum_r  <= 16'h0000;
            full_r      <= 1'b0;
            done_r      <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            mem_we_r <= write_s;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r    <= ST_LOAD;
                        count_r    <= '0;
                        checksum_r <= 16'h0000;
                        full_r     <= 1'b0;
                        done_r     <= 1'b0;
                        err_r      <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (write_s) begin
                        mem_addr_r  <= count_r[ADDR_W-1:0];
                        mem_wdata_r <= word_s;
                        wr_imm_r    <= imm_s;
                        count_r     <= count_r + ONE_C;
                        checksum_r  <= checksum_next(checksum_r, word_s);
                    end
                    if (accept_s && !legal_s) begin
                        err_r <= 1'b1;
                    end
                    if (last_s) begin
                        full_r <= 1'b1;
                    end
                    // A beat taken alongside finish has already been written above.
                    if (last_s || finish) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_we      = mem_we_r;
    assign mem_addr    = mem_addr_r;
    assign mem_wdata   = mem_wdata_r;
    assign wr_imm      = wr_imm_r;
    assign count       = count_r;
    assign checksum    = checksum_r;
    assign full        = full_r;
    assign done        = done_r;
    assign err_illegal = err_r;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed scenarios plus randomized sessions,
// checked every cycle against a queue-based model of the loaded program.
module tb_instr_loader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       finish = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_op = 4'd0, in_rs1 = 4'd0, in_rs2 = 4'd0, in_ra = 4'd0;

    logic       a_ready, a_we, a_imm, a_full, a_done, a_err;
    logic [7:0] a_addr;
    logic [15:0] a_data, a_sum;
    logic [8:0] a_count;
    logic       b_ready, b_we, b_imm, b_full, b_done, b_err;
    logic [7:0] b_addr;
    logic [15:0] b_data, b_sum;
    logic [8:0] b_count;

    logic       sel = 1'b0;
    logic       o_ready, o_we, o_imm, o_full, o_done, o_err;
    logic [7:0] o_addr;
    logic [15:0] o_data, o_sum;
    logic [8:0] o_count;

    instr_loader #(.ADDR_W(8), .DEPTH(256), .MAX_OP(8)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(a_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_ra(in_ra),
        .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_data), .wr_imm(a_imm),
        .count(a_count), .checksum(a_sum), .full(a_full), .done(a_done),
        .err_illegal(a_err)
    );

    instr_loader #(.ADDR_W(8), .DEPTH(4), .MAX_OP(8)) dut4 (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(b_ready),
        .in_op(in_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_ra(in_ra),
        .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_data), .wr_imm(b_imm),
        .count(b_count), .checksum(b_sum), .full(b_full), .done(b_done),
        .err_illegal(b_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        o_ready = sel ? b_ready : a_ready;
        o_we    = sel ? b_we    : a_we;
        o_addr  = sel ? b_addr  : a_addr;
        o_data  = sel ? b_data  : a_data;
        o_imm   = sel ? b_imm   : a_imm;
        o_count = sel ? b_count : a_count;
        o_sum   = sel ? b_sum   : a_sum;
        o_full  = sel ? b_full  : a_full;
        o_done  = sel ? b_done  : a_done;
        o_err   = sel ? b_err   : a_err;
    end

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: session phase (0 idle, 1 loading, 2 closed) and the list of written words.
    int          m_phase = 0;
    int          m_depth = 256;
    logic [15:0] m_words[$];
    bit          m_err = 1'b0;
    bit          e_we = 1'b0;
    logic [7:0]  e_addr = 8'd0;
    logic [15:0] e_data = 16'd0;
    bit          e_imm = 1'b0;
    int          we_seen = 0;

    function automatic logic [15:0] model_sum();
        logic [15:0] s = 16'd0;
        foreach (m_words[i]) s = s ^ m_words[i];
        return s;
    endfunction

    task automatic model_clear();
        m_phase = 0;
        m_words.delete();
        m_err  = 1'b0;
        e_we   = 1'b0;
        e_addr = 8'd0;
        e_data = 16'd0;
        e_imm  = 1'b0;
    endtask

    // One clock: predict, check in_ready, clock, then check all outputs.
    task automatic step();
        bit rdy, acc, legal, was_rst;
        logic [15:0] w;
        #1;
        rdy = (m_phase == 1) && (m_words.size() < m_depth);
        n_vec++;
        if (o_ready !== rdy) begin
            n_bad++;
            $display("FAIL in_ready t=%0t got %b want %b", $time, o_ready, rdy);
        end
        acc     = in_valid && rdy;
        legal   = (in_op <= 4'd8);
        w       = {in_op, in_rs1, in_rs2, in_ra};
        was_rst = rst;
        e_we    = 1'b0;
        if (rst) begin
            model_clear();
        end else if (m_phase != 1) begin
            if (start) begin
                m_phase = 1;
                m_words.delete();
                m_err = 1'b0;
            end
        end else begin
            if (acc && legal) begin
                e_we   = 1'b1;
                e_addr = 8'(m_words.size());
                e_data = w;
                e_imm  = (in_op >= 4'd5) && (in_op <= 4'd8);
                m_words.push_back(w);
            end else if (acc) begin
                m_err = 1'b1;
            end
            if (m_words.size() == m_depth || finish) m_phase = 2;
        end
        @(posedge clk);
        @(negedge clk);
        if (o_we === 1'b1) we_seen++;
        n_vec++;
        if (o_we !== e_we) begin
            n_bad++;
            $display("FAIL mem_we t=%0t got %b want %b", $time, o_we, e_we);
        end
        n_vec++;
        if (o_count !== 9'(m_words.size())) begin
            n_bad++;
            $display("FAIL count t=%0t got %0d want %0d", $time, o_count, m_words.size());
        end
        n_vec++;
        if (o_sum !== model_sum()) begin
            n_bad++;
            $display("FAIL checksum t=%0t got %h want %h", $time, o_sum, model_sum());
        end
        n_vec++;
        if (o_full !== (m_words.size() == m_depth)) begin
            n_bad++;
            $display("FAIL full t=%0t got %b want %b", $time, o_full, m_words.size() == m_depth);
        end
        n_vec++;
        if (o_done !== (m_phase == 2)) begin
            n_bad++;
            $display("FAIL done t=%0t got %b want %b", $time, o_done, m_phase == 2);
        end
        n_vec++;
        if (o_err !== m_err) begin
            n_bad++;
            $display("FAIL err_illegal t=%0t got %b want %b", $time, o_err, m_err);
        end
        if (e_we || was_rst) begin
            n_vec++;
            if (o_addr !== e_addr || o_data !== e_data || o_imm !== e_imm) begin
                n_bad++;
                $display("FAIL write_port t=%0t got %h/%h/%b want %h/%h/%b",
                         $time, o_addr, o_data, o_imm, e_addr, e_data, e_imm);
            end
        end
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input logic [3:0] r1,
                         input logic [3:0] r2, input logic [3:0] ra,
                         input bit st, input bit fin);
        in_valid = v;
        in_op    = op;
        in_rs1   = r1;
        in_rs2   = r2;
        in_ra    = ra;
        start    = st;
        finish   = fin;
        step();
    endtask

    task automatic hard_reset(input bit use_small);
        sel      = use_small;
        m_depth  = use_small ? 4 : 256;
        in_valid = 1'b0;
        start    = 1'b0;
        finish   = 1'b0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        hard_reset(1'b0);
        rst = 1'b1;
        drive(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 1'b1, 1'b0);
        rst = 1'b0;
        n_vec++;
        if (o_ready !== 1'b0 || o_count !== 9'd0 || o_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_state got rdy=%b cnt=%0d done=%b want 0/0/0", o_ready, o_count, o_done);
        end
    endtask

    task automatic test_basic();
        hard_reset(1'b0);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        drive(1'b1, 4'd1, 4'd2, 4'd3, 4'd4, 1'b0, 1'b0);
        n_vec++;
        if (o_data !== 16'h1234 || o_addr !== 8'd0) begin
            n_bad++;
            $display("FAIL basic_w0 got %h@%h want 1234@00", o_data, o_addr);
        end
        drive(1'b1, 4'd5, 4'd1, 4'd0, 4'd7, 1'b0, 1'b0);
        n_vec++;
        if (o_data !== 16'h5107 || o_addr !== 8'd1 || o_imm !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_w1 got %h@%h imm=%b want 5107@01 imm=1", o_data, o_addr, o_imm);
        end
        drive(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        n_vec++;
        if (o_count !== 9'd3 || o_sum !== 16'h4333 || o_done !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_end got cnt=%0d sum=%h done=%b want 3/4333/1", o_count, o_sum, o_done);
        end
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        hard_reset(1'b0);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        we_seen = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'($urandom_range(0, 8)), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1'b0);
        end
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
        n_vec++;
        if (we_seen !== 8 || o_count !== 9'd8) begin
            n_bad++;
            $display("FAIL b2b got we_cycles=%0d cnt=%0d want 8/8", we_seen, o_count);
        end
    endtask

    task automatic test_illegal();
        hard_reset(1'b0);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        drive(1'b1, 4'd2, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0);
        drive(1'b1, 4'd9, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0);
        drive(1'b1, 4'd8, 4'd4, 4'd4, 4'd4, 1'b0, 1'b0);
        n_vec++;
        if (o_err !== 1'b1 || o_count !== 9'd2 || o_addr !== 8'd1 || o_data !== 16'h8444) begin
            n_bad++;
            $display("FAIL illegal got err=%b cnt=%0d last=%h@%h want 1/2/8444@01", o_err, o_count, o_data, o_addr);
        end
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic test_full();
        hard_reset(1'b1);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'd3, 4'(i), 4'd0, 4'd1, 1'b0, 1'b0);
        end
        #1;
        n_vec++;
        if (o_full !== 1'b1 || o_done !== 1'b1 || o_count !== 9'd4 || o_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full got full=%b done=%b cnt=%0d rdy=%b want 1/1/4/0", o_full, o_done, o_count, o_ready);
        end
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        hard_reset(1'b0);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        drive(1'b1, 4'd1, 4'd1, 4'd1, 4'd1, 1'b0, 1'b0);
        drive(1'b1, 4'd2, 4'd2, 4'd2, 4'd2, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 4'd3, 4'd3, 4'd3, 4'd3, 1'b0, 1'b0);
        rst = 1'b0;
        n_vec++;
        if (o_we !== 1'b0 || o_count !== 9'd0 || o_sum !== 16'd0 || o_addr !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_mid got we=%b cnt=%0d sum=%h addr=%h want 0", o_we, o_count, o_sum, o_addr);
        end
        drive(1'b1, 4'd4, 4'd4, 4'd4, 4'd4, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        drive(1'b1, 4'd6, 4'd5, 4'd5, 4'd5, 1'b0, 1'b0);
        n_vec++;
        if (o_addr !== 8'd0 || o_data !== 16'h6555) begin
            n_bad++;
            $display("FAIL restart got %h@%h want 6555@00", o_data, o_addr);
        end
    endtask

    task automatic test_finish_coincident();
        hard_reset(1'b0);
        drive(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        drive(1'b1, 4'd7, 4'd1, 4'd2, 4'd3, 1'b0, 1'b1);
        #1;
        n_vec++;
        if (o_we !== 1'b1 || o_data !== 16'h7123 || o_done !== 1'b1 || o_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL fin_beat got we=%b data=%h done=%b rdy=%b want 1/7123/1/0", o_we, o_data, o_done, o_ready);
        end
        drive(1'b1, 4'd1, 4'd1, 4'd1, 4'd1, 1'b0, 1'b1);
    endtask

    task automatic test_random(input bit use_small);
        hard_reset(use_small);
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 149) == 0);
            drive($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                  $urandom_range(0, 14) == 0, $urandom_range(0, 24) == 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_full();
        test_reset_mid();
        test_finish_coincident();
        test_random(1'b0);
        test_random(1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
